// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared I2C constants: arbiter state encoding, default guard/timeout lengths
// and width helpers used by the setup engine, the poll engine and the bus arbiter.
package i2c_bus_arbiter_pkg;

  localparam int GUARD_CYCLES_DEFAULT   = 16;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1048576;
  localparam int HOLD_CNT_MIN_WIDTH     = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_select.sv
// Round-robin selector: picks the first asserted request after index 'last',
// wrapping modulo NUM_REQ, so the previous owner has lowest priority.
module rr_select
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [idx_width(NUM_REQ)-1:0]  last,
  output logic                           valid,
  output logic [idx_width(NUM_REQ)-1:0]  winner
);

  localparam int IDW = idx_width(NUM_REQ);

  logic [IDW-1:0] cand;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(last) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one open-drain I2C bus between NUM_REQ masters: round-robin grant,
// idle guard time between owners, and forced release of a hung owner.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GUARD_CYCLES   = GUARD_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             scl_low_in,
  input  logic [NUM_REQ-1:0]             sda_low_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           scl_oe,
  output logic                           sda_oe,
  output logic                           busy,
  output logic                           timeout,
  output logic [idx_width(NUM_REQ)-1:0]  timeout_id
);

  localparam int IDW = idx_width(NUM_REQ);
  localparam int HCW = max_int(HOLD_CNT_MIN_WIDTH, $clog2(TIMEOUT_CYCLES) + 1);
  localparam int GCW = $clog2(GUARD_CYCLES) + 1;
  localparam logic [HCW-1:0] HOLD_LAST  = HCW'(TIMEOUT_CYCLES - 1);
  localparam logic [GCW-1:0] GUARD_LAST = GCW'(GUARD_CYCLES - 1);

  arb_state_e      state;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  last_owner;
  logic [HCW-1:0]  hold_cnt;
  logic [GCW-1:0]  guard_cnt;
  logic [NUM_REQ-1:0] lockout;

  logic            rr_valid;
  logic [IDW-1:0]  rr_winner;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .req    (req & ~lockout),
    .last   (last_owner),
    .valid  (rr_valid),
    .winner (rr_winner)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= IDW'(NUM_REQ - 1);
      hold_cnt   <= '0;
      guard_cnt  <= '0;
      lockout    <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      timeout <= 1'b0;
      // A lockout clears once the locked requester is seen with req low.
      lockout <= lockout & req;
      case (state)
        ST_IDLE: begin
          if (rr_valid) begin
            state      <= ST_OWNED;
            owner      <= rr_winner;
            last_owner <= rr_winner;
            hold_cnt   <= '0;
            grant      <= NUM_REQ'(1) << rr_winner;
            busy       <= 1'b1;
          end
        end
        ST_OWNED: begin
          // A release on the expiry edge is a normal release, hence checked first.
          if (!req[owner] || hold_cnt == HOLD_LAST) begin
            state     <= ST_GUARD;
            grant     <= '0;
            guard_cnt <= '0;
            hold_cnt  <= '0;
            if (req[owner]) begin
              timeout        <= 1'b1;
              timeout_id     <= owner;
              lockout[owner] <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Owner's line intents pass straight through; everyone else is ignored.
  always_comb begin
    scl_oe = (state == ST_OWNED) && scl_low_in[owner];
    sda_oe = (state == ST_OWNED) && sda_low_in[owner];
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with NUM_REQ=2, GUARD_CYCLES=4,
// TIMEOUT_CYCLES=32; expected values are hand-derived per step.
module tb_i2c_bus_arbiter;

  logic       clock;
  logic       reset;
  logic [1:0] req;
  logic [1:0] scl_low_in;
  logic [1:0] sda_low_in;
  logic [1:0] grant;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       timeout;
  logic [0:0] timeout_id;

  int n_cmp = 0;
  int n_err = 0;

  i2c_bus_arbiter #(
    .NUM_REQ        (2),
    .GUARD_CYCLES   (4),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .scl_low_in (scl_low_in),
    .sda_low_in (sda_low_in),
    .grant      (grant),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .timeout    (timeout),
    .timeout_id (timeout_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;

    reset = 1'b0; req = 2'b00; scl_low_in = 2'b00; sda_low_in = 2'b00;
    #12;
    check("rst_grant",   grant,   0);
    check("rst_busy",    busy,    0);
    check("rst_timeout", timeout, 0);
    check("rst_tid",     timeout_id, 0);
    check("rst_scl",     scl_oe,  0);

    // First arbitration after reset: index 0 wins, one-cycle latency.
    reset = 1'b1; req = 2'b11;
    tick(1);
    check("first_grant", grant, 2'b01);
    check("first_busy",  busy,  1);
    scl_low_in = 2'b10; sda_low_in = 2'b01;
    #1;
    check("own0_scl", scl_oe, 0);
    check("own0_sda", sda_oe, 1);

    // Release by owner 0: guard for 4 clocks, one idle clock, then grant 1.
    req = 2'b10;
    tick(1);
    check("rel0_grant", grant, 2'b00);
    check("rel0_busy",  busy,  1);
    check("rel0_scl",   scl_oe, 0);
    tick(3);
    check("guard_end_busy",  busy,  1);
    check("guard_end_grant", grant, 2'b00);
    tick(1);
    check("idle_busy",  busy,  0);
    check("idle_grant", grant, 2'b00);
    tick(1);
    check("second_grant", grant, 2'b10);

    // Owner 1 line pass-through, no latency.
    #1;
    check("own1_scl", scl_oe, 1);
    check("own1_sda", sda_oe, 0);
    scl_low_in = 2'b01; sda_low_in = 2'b10;
    #1;
    check("own1_scl_b", scl_oe, 0);
    check("own1_sda_b", sda_oe, 1);

    // Non-owner request during OWNED has no effect.
    req = 2'b11;
    tick(2);
    check("nonowner_grant", grant, 2'b10);

    // Owner 1 releases; requester 0 waits out the guard.
    req = 2'b01;
    tick(4);
    check("held_off_grant", grant, 2'b00);
    tick(1);
    check("held_off_idle", grant, 2'b00);
    tick(1);
    check("third_grant", grant, 2'b01);
    req = 2'b00;
    tick(5);
    check("idle_again", busy, 0);

    // Timeout on owner 1: pulse at the 32nd owned clock.
    req = 2'b10;
    tick(1);
    check("to_grant", grant, 2'b10);
    tick(31);
    check("to_pre_pulse", timeout, 0);
    check("to_pre_grant", grant, 2'b10);
    tick(1);
    check("to_pulse", timeout, 1);
    check("to_id",    timeout_id, 1);
    check("to_grant_drop", grant, 2'b00);
    tick(1);
    check("to_pulse_end", timeout, 0);
    tick(6);
    check("locked_grant", grant, 2'b00);
    check("locked_busy",  busy,  0);
    req = 2'b00;
    tick(1);
    req = 2'b10;
    tick(1);
    check("unlock_grant", grant, 2'b10);

    // Release on the expiry edge: no pulse, no lockout.
    tick(31);
    check("exp_pre_grant", grant, 2'b10);
    req = 2'b00;
    tick(1);
    check("exp_rel_timeout", timeout, 0);
    check("exp_rel_grant",   grant, 2'b00);
    check("exp_rel_busy",    busy, 1);
    req = 2'b10;
    tick(1);
    check("exp_rel_timeout2", timeout, 0);
    check("exp_rel_tid", timeout_id, 1);
    tick(3);
    check("exp_rel_idle", grant, 2'b00);
    tick(1);
    check("no_lockout_grant", grant, 2'b10);

    // Asynchronous reset mid-OWNED.
    scl_low_in = 2'b10; sda_low_in = 2'b10;
    #1;
    check("pre_rst_scl", scl_oe, 1);
    check("pre_rst_sda", sda_oe, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_grant", grant,  2'b00);
    check("async_scl",   scl_oe, 0);
    check("async_sda",   sda_oe, 0);
    check("async_busy",  busy,   0);
    check("async_tid",   timeout_id, 0);
    #1;
    reset = 1'b1;
    tick(1);
    check("post_rst_grant", grant, 2'b10);

    // Back-to-back 10-clock transactions alternate owners.
    scl_low_in = 2'b00; sda_low_in = 2'b00;
    req = 2'b00;
    tick(5);
    check("pre_rr_idle", busy, 0);
    req = 2'b11;
    exp_g = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check($sformatf("rr%0d_grant", k), grant, exp_g);
      tick(9);
      check($sformatf("rr%0d_hold", k), grant, exp_g);
      req = 2'b11 & ~exp_g;
      tick(1);
      check($sformatf("rr%0d_rel", k), grant, 2'b00);
      req = 2'b11;
      tick(3);
      check($sformatf("rr%0d_guard", k), busy, 1);
      tick(1);
      check($sformatf("rr%0d_idle", k), busy, 0);
      exp_g = {exp_g[0], exp_g[1]};
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
